hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the five-stage MIPS datapath. It owns the `PCWrite` input of the program counter and the write enable of the IF/ID register. It detects load-use and branch-operand hazards, freezes PC and IF/ID for the required number of cycles, and injects bubbles into ID/EX. It also squashes the fetched instruction when a branch or jump resolves taken in ID.

## Interface
- No parameters; widths fixed by the ISA (5-bit register IDs).
- `Clk` in 1: rising-edge clock, shared with the program counter.
- `Reset` in 1: asynchronous, active-high.
- `ID_Rs` in 5: rs field of the instruction in ID.
- `ID_Rt` in 5: rt field of the instruction in ID.
- `ID_UsesRt` in 1: instruction in ID reads rt as a source.
- `ID_IsBranch` in 1: instruction in ID is beq/bne (compared in ID).
- `ID_BranchTaken` in 1: branch resolved taken in ID this cycle.
- `ID_Jump` in 1: j/jal/jr in ID this cycle.
- `EX_MemRead` in 1: instruction in EX is a load.
- `EX_RegWrite` in 1: instruction in EX writes a register.
- `EX_WriteReg` in 5: destination register of the instruction in EX.
- `MEM_MemRead` in 1: instruction in MEM is a load.
- `MEM_WriteReg` in 5: destination register of the instruction in MEM.
- `PCWrite` out 1: 1 = PC loads its next address; 0 = PC holds.
- `IFIDWrite` out 1: 1 = IF/ID register loads; 0 = IF/ID holds.
- `IDEXBubble` out 1: 1 = zero all ID/EX control bits.
- `IFIDFlush` out 1: 1 = IF/ID loads a nop.

## Operation
- Source match: `match(R) = (R != 0) && (R == ID_Rs || (ID_UsesRt && R == ID_Rt))`. Register 0 never causes a hazard.
- Required stall count N, evaluated only in state RUN:
  - N = 2: `EX_MemRead && match(EX_WriteReg) && ID_IsBranch`.
  - N = 1: `EX_MemRead && match(EX_WriteReg) && !ID_IsBranch`.
  - N = 1: `ID_IsBranch && EX_RegWrite && !EX_MemRead && match(EX_WriteReg)`.
  - N = 1: `ID_IsBranch && MEM_MemRead && match(MEM_WriteReg)`.
  - N = 0 otherwise. If several conditions hold, the largest N wins.
- FSM states: RUN and HOLD. A 2-bit `remaining` counter is used.
  - RUN with N > 0: stall in this cycle. If N = 2, go to HOLD with `remaining` = 1. If N = 1, stay in RUN; the hazard is re-evaluated next cycle.
  - HOLD: stall unconditionally and ignore all hazard inputs. Decrement `remaining`. Return to RUN when it reaches 0.
- Stall cycle outputs: `PCWrite`=0, `IFIDWrite`=0, `IDEXBubble`=1, `IFIDFlush`=0.
- Flush: in RUN with N = 0, `IFIDFlush` = `ID_BranchTaken || ID_Jump`, with `PCWrite`=1 and `IFIDWrite`=1.
- Stall has priority over flush. A branch that is stalling is not yet resolved, so taken/jump inputs are ignored during any stall cycle.
- Normal cycle outputs: `PCWrite`=1, `IFIDWrite`=1, `IDEXBubble`=0, `IFIDFlush`=0.

## Timing
- All outputs are combinational from state, `remaining` and current inputs, so a hazard seen in cycle t holds the PC at the edge ending cycle t (zero-cycle latency).
- State and `remaining` update on the rising edge of `Clk`.
- Reset, asynchronous: state = RUN, `remaining` = 0.
- While `Reset` is high, outputs are forced to `PCWrite`=1, `IFIDWrite`=1, `IDEXBubble`=0, `IFIDFlush`=0.
- Reset asserted during HOLD aborts the stall immediately. The first cycle after reset is RUN.
- Number of consecutive stall cycles for one hazard:
  - load → branch dependency: exactly 2;
  - load → ALU use: exactly 1;
  - ALU → branch: 1;
  - load in MEM → branch: 1.
- Back-to-back hazards: each new RUN cycle re-evaluates the inputs, so stalls chain with no gap.

## Configuration
- `HAZARD_STATS_EN` defined: adds `StallCount` out 32 and `FlushCount` out 32.
  - Both reset to 0.
  - Each increments by 1 on every rising edge where its corresponding output was asserted, and saturates at 0xFFFFFFFF.
- `HAZARD_STATS_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `hazard_pkg` holds:
  - FSM state encoding (RUN=0, HOLD=1);
  - constants `LOAD_USE_STALLS`=1 and `LOAD_BRANCH_STALLS`=2;
  - the width of `remaining`.
- One sub-module, `hazard_reg_match`: combinational 5-bit comparator implementing `match(R)` with the register-0 exclusion. It is instantiated twice, for `EX_WriteReg` and `MEM_WriteReg`.

## Test plan
- Load-use: EX=lw $t0 (`EX_MemRead`=1, `EX_WriteReg`=8), ID reads `ID_Rs`=8, not a branch → exactly 1 cycle with `PCWrite`=0 and `IDEXBubble`=1, then `PCWrite`=1.
- Load → branch: same EX load, `ID_IsBranch`=1, `ID_Rt`=8, `ID_UsesRt`=1 → 2 consecutive stall cycles. In the 2nd cycle (HOLD), changing the EX inputs has no effect.
- Register 0: `EX_MemRead`=1, `EX_WriteReg`=0, `ID_Rs`=0 → no stall, `PCWrite`=1 throughout.
- Taken branch with no hazard: `ID_BranchTaken`=1 → `IFIDFlush`=1 for one cycle, `PCWrite`=1. The same input during a stall cycle → `IFIDFlush`=0.
- Reset mid-HOLD: assert `Reset` asynchronously in the 2nd load-branch stall cycle → outputs go to the normal values immediately, and RUN is entered after release.
- With `HAZARD_STATS_EN`: run the load-branch case followed by one taken jump → `StallCount`=2, `FlushCount`=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding, stall-length constants and the width of the stall counter.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int REMAINING_W = 2;

  localparam logic [REMAINING_W-1:0] LOAD_USE_STALLS    = 2'd1;
  localparam logic [REMAINING_W-1:0] LOAD_BRANCH_STALLS = 2'd2;

endpackage

// File: rtl/hazard_reg_match.sv
// Source-operand comparator: does a producer register feed the instruction in ID?
// Register 0 is hard-wired to zero and never creates a dependency.
module hazard_reg_match (
  input  logic [4:0] WriteReg,
  input  logic [4:0] Rs,
  input  logic [4:0] Rt,
  input  logic       UsesRt,
  output logic       Match
);

  assign Match = (WriteReg != 5'd0) &&
                 ((WriteReg == Rs) || (UsesRt && (WriteReg == Rt)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard controller: freezes PC and IF/ID, bubbles ID/EX,
// and flushes IF/ID on taken branches/jumps. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_stall_unit
  import hazard_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_IsBranch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  state_t                 state_reg, state_next;
  logic [REMAINING_W-1:0] remaining_reg, remaining_next;

  // Index 0 compares the EX destination, index 1 the MEM destination.
  logic [4:0] write_reg [2];
  logic [1:0] match_vec;

  assign write_reg[0] = EX_WriteReg;
  assign write_reg[1] = MEM_WriteReg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_match
      hazard_reg_match u_match (
        .WriteReg (write_reg[gi]),
        .Rs       (ID_Rs),
        .Rt       (ID_Rt),
        .UsesRt   (ID_UsesRt),
        .Match    (match_vec[gi])
      );
    end
  endgenerate

  logic ex_load_dep;
  logic need_two;
  logic need_one;

  assign ex_load_dep = EX_MemRead && match_vec[0];
  assign need_two    = ex_load_dep && ID_IsBranch;
  assign need_one    = (ex_load_dep && !ID_IsBranch) ||
                       (ID_IsBranch && EX_RegWrite && !EX_MemRead && match_vec[0]) ||
                       (ID_IsBranch && MEM_MemRead && match_vec[1]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= RUN;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    PCWrite        = 1'b1;
    IFIDWrite      = 1'b1;
    IDEXBubble     = 1'b0;
    IFIDFlush      = 1'b0;

    case (state_reg)
      RUN: begin
        if (need_two || need_one) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          // Two-cycle stall: this cycle plus the cycles counted down in HOLD.
          if (need_two) begin
            state_next     = HOLD;
            remaining_next = LOAD_BRANCH_STALLS - LOAD_USE_STALLS;
          end
        end else begin
          IFIDFlush = ID_BranchTaken || ID_Jump;
        end
      end
      HOLD: begin
        PCWrite        = 1'b0;
        IFIDWrite      = 1'b0;
        IDEXBubble     = 1'b1;
        remaining_next = remaining_reg - REMAINING_W'(1);
        if (remaining_next == '0) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next     = RUN;
        remaining_next = '0;
      end
    endcase

    // While reset is held the pipeline runs freely, even if a stall was in progress.
    if (Reset) begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXBubble = 1'b0;
      IFIDFlush  = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_reg;
  logic [31:0] flush_count_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (IDEXBubble && (stall_count_reg != 32'hFFFF_FFFF)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
      if (IFIDFlush && (flush_count_reg != 32'hFFFF_FFFF)) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign StallCount = stall_count_reg;
  assign FlushCount = flush_count_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit: one table row per cycle, plus
// hand sequences for reset during a stall and (with HAZARD_STATS_EN) the counters.
module tb_hazard_stall_unit;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_IsBranch;
  logic        ID_BranchTaken;
  logic        ID_Jump;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_WriteReg;
  logic        MEM_MemRead;
  logic [4:0]  MEM_WriteReg;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount;
  logic [31:0] FlushCount;
`endif

  hazard_stall_unit dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_IsBranch    (ID_IsBranch),
    .ID_BranchTaken (ID_BranchTaken),
    .ID_Jump        (ID_Jump),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_WriteReg    (EX_WriteReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_WriteReg   (MEM_WriteReg),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXBubble     (IDEXBubble),
    .IFIDFlush      (IFIDFlush)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected outputs packed as {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}.
  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1101;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       br;
    logic       tk;
    logic       jp;
    logic       exmr;
    logic       exrw;
    logic [4:0] exwr;
    logic       memmr;
    logic [4:0] memwr;
    logic [3:0] exp;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                              input logic br, input logic tk, input logic jp,
                              input logic exmr, input logic exrw, input logic [4:0] exwr,
                              input logic memmr, input logic [4:0] memwr,
                              input logic [3:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ur = ur; v.br = br; v.tk = tk; v.jp = jp;
    v.exmr = exmr; v.exrw = exrw; v.exwr = exwr; v.memmr = memmr; v.memwr = memwr;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [3:0] outs();
    return {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};
  endfunction

  task automatic drive(input vec_t v);
    ID_Rs          = v.rs;
    ID_Rt          = v.rt;
    ID_UsesRt      = v.ur;
    ID_IsBranch    = v.br;
    ID_BranchTaken = v.tk;
    ID_Jump        = v.jp;
    EX_MemRead     = v.exmr;
    EX_RegWrite    = v.exrw;
    EX_WriteReg    = v.exwr;
    MEM_MemRead    = v.memmr;
    MEM_WriteReg   = v.memwr;
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got pcw/ifidw/bub/flush=%b required=%b", name, act, req);
    end else begin
      $display("ok   %s pcw/ifidw/bub/flush=%b", name, act);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask
`endif

  // One table row per clock: drive just after the rising edge, check on the falling edge.
  task automatic step(input string name, input vec_t v);
    @(posedge Clk);
    #1;
    drive(v);
    @(negedge Clk);
    check4(name, outs(), v.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    vec_t lb;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

    //                rs  rt ur br tk jp exmr exrw exwr memmr memwr exp
    vecs[0]  = mk(     0,  0, 0, 0, 0, 0, 0,   0,   0,   0,    0,  NORM);
    vecs[1]  = mk(     8,  2, 1, 0, 0, 0, 1,   1,   8,   0,    0,  STALL); // load-use
    vecs[2]  = mk(     8,  2, 1, 0, 0, 0, 0,   0,   0,   1,    8,  NORM);
    vecs[3]  = mk(     4,  8, 1, 1, 1, 0, 1,   1,   8,   0,    0,  STALL); // load-branch 1
    vecs[4]  = mk(     4,  8, 1, 1, 1, 0, 0,   1,   9,   0,    0,  STALL); // HOLD ignores EX
    vecs[5]  = mk(     4,  8, 1, 1, 1, 0, 0,   0,   0,   0,    0,  FLUSH);
    vecs[6]  = mk(     0,  0, 1, 0, 0, 0, 1,   1,   0,   0,    0,  NORM);  // $zero
    vecs[7]  = mk(     5,  0, 1, 1, 0, 0, 1,   1,   0,   1,    0,  NORM);
    vecs[8]  = mk(     9,  3, 1, 1, 1, 0, 0,   1,   9,   0,    0,  STALL); // ALU->branch
    vecs[9]  = mk(     9,  3, 1, 1, 1, 0, 0,   0,   0,   0,    0,  FLUSH);
    vecs[10] = mk(     3, 10, 1, 1, 0, 0, 0,   0,   0,   1,   10,  STALL); // MEM load->branch
    vecs[11] = mk(     3, 11, 0, 0, 0, 0, 1,   1,  11,   0,    0,  NORM);  // rt not a source
    vecs[12] = mk(     9,  0, 0, 0, 0, 0, 0,   1,   9,   0,    0,  NORM);  // ALU->ALU forwards
    vecs[13] = mk(     0,  0, 0, 0, 0, 1, 0,   0,   0,   0,    0,  FLUSH); // jump
    vecs[14] = mk(     7,  0, 0, 0, 0, 0, 1,   1,   7,   0,    0,  STALL);
    vecs[15] = mk(     6,  0, 0, 0, 0, 0, 1,   1,   6,   0,    0,  STALL); // chained
    vecs[16] = mk(     6, 12, 1, 1, 0, 0, 1,   1,  12,   0,    0,  STALL);
    vecs[17] = mk(     6,  0, 0, 0, 0, 1, 1,   1,   6,   0,    0,  STALL); // HOLD, jump ignored
    vecs[18] = mk(     6,  0, 0, 0, 0, 1, 1,   1,   6,   0,    0,  STALL); // RUN re-evaluates
    vecs[19] = mk(     6,  0, 0, 0, 0, 1, 0,   0,   0,   0,    0,  FLUSH);
    vecs[20] = mk(     0,  0, 0, 0, 0, 0, 0,   0,   0,   0,    0,  NORM);
    vecs[21] = mk(     9,  0, 0, 1, 0, 0, 0,   0,   9,   0,    0,  NORM);  // no RegWrite

    // Reset asserted with a load-use hazard present: outputs must be the normal values.
    Reset = 1'b1;
    drive(vecs[1]);
    @(negedge Clk);
    check4("reset_forced", outs(), NORM);
    #2;
    Reset = 1'b0;
    drive(idle);

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec[%0d]", i), vecs[i]);
    end

    // Reset in the second cycle of a load-branch stall.
    lb = mk(4, 8, 1, 1, 0, 0, 1, 1, 8, 0, 0, STALL);
    step("rst_seq_lb1", lb);
    step("rst_seq_hold", lb);
    #1;
    Reset = 1'b1;
    #1;
    check4("rst_seq_async", outs(), NORM);
    @(posedge Clk);
    #1;
    drive(mk(4, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0, FLUSH));
    #1;
    check4("rst_seq_taken_in_reset", outs(), NORM);
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check4("rst_seq_run_after", outs(), FLUSH);
    step("rst_seq_idle", idle);

`ifdef HAZARD_STATS_EN
    @(negedge Clk);
    Reset = 1'b1;
    drive(idle);
    #2;
    Reset = 1'b0;
    check32("stats_reset_stall", StallCount, 32'd0);
    check32("stats_reset_flush", FlushCount, 32'd0);
    step("stats_lb1", lb);
    step("stats_hold", lb);
    step("stats_jump", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, FLUSH));
    step("stats_idle", idle);
    check32("stats_stall_count", StallCount, 32'd2);
    check32("stats_flush_count", FlushCount, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
